// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle controller (master) and the IR, datapath and memory (slave).
interface mc_control_if #(
  parameter int ALUOP_W = 3
);
  // Memory handshake: memread/memwrite act as valid and stay asserted, with iord stable,
  // until mem_ready (ready) is sampled high on a rising edge. The transfer completes in the
  // cycle where both are high. mem_ready is ignored whenever no request is outstanding.
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               regwrite;
  logic               regdest;
  logic               rd31;
  logic               memtoreg;
  logic               alusrc_a;
  logic [1:0]         alusrc_b;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         branch;
  logic               jump;
  logic               statusregwrite;
  logic               retire;
  logic               fault;
  logic [2:0]         state;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, ir_write, iord, memread, memwrite, regwrite, regdest, rd31, memtoreg,
           alusrc_a, alusrc_b, aluop, branch, jump, statusregwrite, retire, fault, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, ir_write, iord, memread, memwrite, regwrite, regdest, rd31, memtoreg,
           alusrc_a, alusrc_b, aluop, branch, jump, statusregwrite, retire, fault, state
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset controller: sequences FETCH/DECODE/EXEC/MEM/WB, waits on memory with a
// timeout and halts with a sticky fault on illegal instructions or memory timeouts.
module mc_control #(
  parameter int ALUOP_W     = 3,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter bit EXT_EN      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);
  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RTYPE, C_LW, C_SW, C_ORI, C_BEQ, C_BGEZ, C_JPC, C_BALRN, C_JMADD
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_JPC   = 6'b011110;
  localparam logic [5:0] FN_BALRN = 6'b010111;
  localparam logic [5:0] FN_JMADD = 6'b100001;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q;
  logic             waiting;
  logic             timed_out;
  logic [2:0]       aluop3;

  // Instruction class decoded from the live IR fields; captured into cls_q at DECODE.
  always_comb begin
    cls_d = C_ILL;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: cls_d = C_RTYPE;
          FN_BALRN: cls_d = EXT_EN ? C_BALRN : C_ILL;
          FN_JMADD: cls_d = EXT_EN ? C_JMADD : C_ILL;
          default:  cls_d = C_ILL;
        endcase
      end
      OP_LW:   cls_d = C_LW;
      OP_SW:   cls_d = C_SW;
      OP_BEQ:  cls_d = C_BEQ;
      OP_ORI:  cls_d = C_ORI;
      OP_BGEZ: cls_d = EXT_EN ? C_BGEZ : C_ILL;
      OP_JPC:  cls_d = EXT_EN ? C_JPC : C_ILL;
      default: cls_d = C_ILL;
    endcase
  end

  // Only FETCH and MEM carry a memory request, so only they can wait or time out.
  assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
  assign timed_out = waiting && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cls_q   <= C_ILL;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == S_DECODE) cls_q <= cls_d;
      if (state_d == S_HALT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (timed_out) state_d = S_HALT;
                else if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = (cls_d == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_LW, C_SW, C_JMADD:  state_d = S_MEM;
          C_RTYPE, C_ORI, C_JPC: state_d = S_WB;
          C_ILL:                state_d = S_HALT;
          default:              state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (timed_out) state_d = S_HALT;
                else if (bus.mem_ready) state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
    tmo_d = (waiting && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
  end

  always_comb begin
    bus.pc_write       = 1'b0;
    bus.ir_write       = 1'b0;
    bus.iord           = 1'b0;
    bus.memread        = 1'b0;
    bus.memwrite       = 1'b0;
    bus.regwrite       = 1'b0;
    bus.regdest        = 1'b0;
    bus.rd31           = 1'b0;
    bus.memtoreg       = 1'b0;
    bus.alusrc_a       = 1'b0;
    bus.alusrc_b       = 2'b00;
    bus.branch         = 2'b00;
    bus.jump           = 1'b0;
    bus.statusregwrite = 1'b1;
    bus.retire         = 1'b0;
    aluop3             = 3'b000;
    case (state_q)
      S_RST: bus.statusregwrite = 1'b0;
      S_FETCH: begin
        bus.memread  = 1'b1;
        bus.alusrc_b = 2'b01;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_DECODE: bus.alusrc_b = 2'b11;
      S_EXEC: begin
        case (cls_q)
          C_RTYPE: begin bus.alusrc_a = 1'b1; aluop3 = 3'b010; end
          C_LW, C_SW: begin bus.alusrc_a = 1'b1; bus.alusrc_b = 2'b10; end
          C_ORI: begin bus.alusrc_a = 1'b1; bus.alusrc_b = 2'b10; aluop3 = 3'b100; end
          C_BEQ: begin
            bus.alusrc_a = 1'b1; aluop3 = 3'b001; bus.branch = 2'b01; bus.retire = 1'b1;
          end
          C_BGEZ: begin
            bus.alusrc_a = 1'b1; aluop3 = 3'b011; bus.branch = 2'b10; bus.retire = 1'b1;
          end
          C_BALRN: begin
            bus.branch = 2'b11; bus.statusregwrite = 1'b0; bus.retire = 1'b1;
          end
          C_JMADD: bus.alusrc_a = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        bus.iord     = 1'b1;
        bus.memwrite = (cls_q == C_SW);
        bus.memread  = (cls_q != C_SW);
        bus.retire   = (cls_q == C_SW) && bus.mem_ready;
      end
      S_WB: begin
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
        bus.regdest  = (cls_q == C_RTYPE);
        bus.memtoreg = (cls_q == C_LW);
        bus.rd31     = (cls_q == C_JPC) || (cls_q == C_JMADD);
        bus.jump     = (cls_q == C_JMADD);
        bus.pc_write = (cls_q == C_JMADD);
      end
      S_HALT: bus.statusregwrite = 1'b0;
      default: bus.statusregwrite = 1'b0;
    endcase
  end

  assign bus.aluop = ALUOP_W'(aluop3);
  assign bus.fault = fault_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class, memory waits, timeout, illegal decode and reset.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  mc_control_if #(.ALUOP_W(3)) if0 ();
  mc_control_if #(.ALUOP_W(3)) if1 ();

  mc_control #(.EXT_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mc_control #(.EXT_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle view: drive mem_ready just after the falling edge, then let comb settle.
  task automatic next_cycle(input logic rdy);
    @(negedge clk);
    if0.mem_ready = rdy;
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    if0.opcode = op;
    if0.funct  = fn;
  endtask

  // Runs one instruction from a FETCH view; mem_ready low for 'waits' MEM cycles, high elsewhere.
  task automatic measure(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int waits, input int exp_lat);
    int lat = 0;
    int ret = 0;
    int w   = waits;
    set_instr(op, fn);
    if0.mem_ready = 1'b1;
    #1;
    check_eq({tag, "_start"}, 32'(if0.state), 32'd1);
    do begin
      if (if0.retire) ret++;
      lat++;
      @(negedge clk);
      if (if0.state == 3'd4 && w > 0) begin
        if0.mem_ready = 1'b0;
        w--;
      end else begin
        if0.mem_ready = 1'b1;
      end
      #1;
    end while (if0.state != 3'd1 && if0.state != 3'd7 && lat < 40);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_retire"}, 32'(ret), 32'd1);
    check_eq({tag, "_end"}, 32'(if0.state), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    set_instr(6'b000000, 6'b100000);
    if0.mem_ready = 1'b1;
    if1.opcode = 6'b000000;
    if1.funct = 6'b100000;
    if1.mem_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_state", 32'(if0.state), 32'd0);
    check_eq("rst_memread", 32'(if0.memread), 32'd0);
    check_eq("rst_srw", 32'(if0.statusregwrite), 32'd0);
    check_eq("rst_fault", 32'(if0.fault), 32'd0);
    check_eq("rst_irw", 32'(if0.ir_write), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rt_s0", 32'(if0.state), 32'd0);

    // R-type add: 0,1,2,3,5,1
    next_cycle(1'b1);
    check_eq("rt_s1", 32'(if0.state), 32'd1);
    check_eq("rt_f_memread", 32'(if0.memread), 32'd1);
    check_eq("rt_f_irw", 32'(if0.ir_write), 32'd1);
    check_eq("rt_f_pcw", 32'(if0.pc_write), 32'd1);
    check_eq("rt_f_srcb", 32'(if0.alusrc_b), 32'd1);
    check_eq("rt_f_iord", 32'(if0.iord), 32'd0);
    next_cycle(1'b1);
    check_eq("rt_s2", 32'(if0.state), 32'd2);
    check_eq("rt_d_srcb", 32'(if0.alusrc_b), 32'd3);
    check_eq("rt_d_irw", 32'(if0.ir_write), 32'd0);
    check_eq("rt_d_srw", 32'(if0.statusregwrite), 32'd1);
    next_cycle(1'b1);
    check_eq("rt_s3", 32'(if0.state), 32'd3);
    check_eq("rt_e_srca", 32'(if0.alusrc_a), 32'd1);
    check_eq("rt_e_aluop", 32'(if0.aluop), 32'd2);
    check_eq("rt_e_retire", 32'(if0.retire), 32'd0);
    next_cycle(1'b1);
    check_eq("rt_s5", 32'(if0.state), 32'd5);
    check_eq("rt_w_regwrite", 32'(if0.regwrite), 32'd1);
    check_eq("rt_w_regdest", 32'(if0.regdest), 32'd1);
    check_eq("rt_w_retire", 32'(if0.retire), 32'd1);
    check_eq("rt_w_memtoreg", 32'(if0.memtoreg), 32'd0);
    check_eq("rt_dut1_wb", 32'(if1.state), 32'd5);
    next_cycle(1'b1);
    check_eq("rt_s1_again", 32'(if0.state), 32'd1);

    // balrn
    set_instr(6'b000000, 6'b010111);
    next_cycle(1'b1);
    next_cycle(1'b1);
    check_eq("balrn_exec", 32'(if0.state), 32'd3);
    check_eq("balrn_branch", 32'(if0.branch), 32'd3);
    check_eq("balrn_srw", 32'(if0.statusregwrite), 32'd0);
    check_eq("balrn_retire", 32'(if0.retire), 32'd1);
    next_cycle(1'b1);
    check_eq("balrn_fetch", 32'(if0.state), 32'd1);

    // jmadd with one MEM wait
    set_instr(6'b000000, 6'b100001);
    next_cycle(1'b1);
    next_cycle(1'b1);
    check_eq("jm_e_srca", 32'(if0.alusrc_a), 32'd1);
    check_eq("jm_e_aluop", 32'(if0.aluop), 32'd0);
    next_cycle(1'b0);
    check_eq("jm_m_state", 32'(if0.state), 32'd4);
    check_eq("jm_m_memread", 32'(if0.memread), 32'd1);
    check_eq("jm_m_iord", 32'(if0.iord), 32'd1);
    check_eq("jm_m_memwrite", 32'(if0.memwrite), 32'd0);
    next_cycle(1'b1);
    check_eq("jm_m_hold", 32'(if0.state), 32'd4);
    next_cycle(1'b1);
    check_eq("jm_w_state", 32'(if0.state), 32'd5);
    check_eq("jm_w_jump", 32'(if0.jump), 32'd1);
    check_eq("jm_w_pcw", 32'(if0.pc_write), 32'd1);
    check_eq("jm_w_rd31", 32'(if0.rd31), 32'd1);
    check_eq("jm_w_regwrite", 32'(if0.regwrite), 32'd1);
    next_cycle(1'b1);
    check_eq("jm_fetch", 32'(if0.state), 32'd1);

    // lw with three wait cycles in MEM
    set_instr(6'b100011, 6'b000000);
    next_cycle(1'b1);
    next_cycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(1'b0);
      check_eq($sformatf("lw_wait%0d_state", i), 32'(if0.state), 32'd4);
      check_eq($sformatf("lw_wait%0d_memread", i), 32'(if0.memread), 32'd1);
      check_eq($sformatf("lw_wait%0d_iord", i), 32'(if0.iord), 32'd1);
    end
    next_cycle(1'b1);
    check_eq("lw_m_ready", 32'(if0.state), 32'd4);
    next_cycle(1'b1);
    check_eq("lw_w_state", 32'(if0.state), 32'd5);
    check_eq("lw_w_memtoreg", 32'(if0.memtoreg), 32'd1);
    check_eq("lw_w_regdest", 32'(if0.regdest), 32'd0);
    next_cycle(1'b1);
    check_eq("lw_fetch", 32'(if0.state), 32'd1);

    // latency table
    measure("beq",   6'b000100, 6'b000000, 0, 3);
    measure("bgez",  6'b000001, 6'b000000, 0, 3);
    measure("balrn", 6'b000000, 6'b010111, 0, 3);
    measure("sw",    6'b101011, 6'b000000, 0, 4);
    measure("sub",   6'b000000, 6'b100010, 0, 4);
    measure("ori",   6'b001101, 6'b000000, 0, 4);
    measure("jpc",   6'b011110, 6'b000000, 0, 4);
    measure("lw",    6'b100011, 6'b000000, 0, 5);
    measure("jmadd", 6'b000000, 6'b100001, 0, 5);
    measure("lw_w3", 6'b100011, 6'b000000, 3, 8);
    measure("sw_w2", 6'b101011, 6'b000000, 2, 6);

    // asynchronous abort in EXEC
    set_instr(6'b000000, 6'b100000);
    next_cycle(1'b1);
    next_cycle(1'b1);
    check_eq("abort_exec", 32'(if0.state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_state", 32'(if0.state), 32'd0);
    check_eq("abort_srca", 32'(if0.alusrc_a), 32'd0);
    check_eq("abort_retire", 32'(if0.retire), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // FETCH timeout after 200 wait cycles
    next_cycle(1'b0);
    check_eq("tmo_first", 32'(if0.state), 32'd1);
    for (int i = 1; i < 200; i++) next_cycle(1'b0);
    check_eq("tmo_last_state", 32'(if0.state), 32'd1);
    check_eq("tmo_last_memread", 32'(if0.memread), 32'd1);
    next_cycle(1'b0);
    check_eq("tmo_halt", 32'(if0.state), 32'd7);
    check_eq("tmo_fault", 32'(if0.fault), 32'd1);
    check_eq("tmo_memread", 32'(if0.memread), 32'd0);
    next_cycle(1'b1);
    next_cycle(1'b1);
    check_eq("tmo_stay", 32'(if0.state), 32'd7);
    check_eq("tmo_irw", 32'(if0.ir_write), 32'd0);
    check_eq("tmo_pcw", 32'(if0.pc_write), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("tmo_rst_fault", 32'(if0.fault), 32'd0);
    check_eq("tmo_rst_state", 32'(if0.state), 32'd0);

    // illegal decode: 111111 on dut0, jpc with extensions disabled on dut1
    set_instr(6'b111111, 6'b000000);
    if1.opcode = 6'b011110;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    next_cycle(1'b1);
    next_cycle(1'b1);
    check_eq("ill_dec_state", 32'(if0.state), 32'd2);
    check_eq("ill_dec_fault", 32'(if0.fault), 32'd0);
    check_eq("ext_dec_state", 32'(if1.state), 32'd2);
    next_cycle(1'b1);
    check_eq("ill_halt", 32'(if0.state), 32'd7);
    check_eq("ill_fault", 32'(if0.fault), 32'd1);
    check_eq("ill_regwrite", 32'(if0.regwrite), 32'd0);
    check_eq("ext_halt", 32'(if1.state), 32'd7);
    check_eq("ext_fault", 32'(if1.fault), 32'd1);
    check_eq("ext_regwrite", 32'(if1.regwrite), 32'd0);
    next_cycle(1'b1);
    check_eq("ill_stay", 32'(if0.state), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
